// File: rtl/spi_master_tx_if.sv
// Bundle of the upstream handshake and SPI pins for spi_master_tx.
// slave = the serialiser itself, master = the block that drives it.
`timescale 1ns/1ps
interface spi_master_tx_if #(
  parameter int DATA_W = 20
);
  logic              insert;
  logic [DATA_W-1:0] data_to_send;
  logic [1:0]        ss;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [3:0]        cs_n;
  logic              busy;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;

  modport slave (
    input  insert, data_to_send, ss, miso,
    output sclk, mosi, cs_n, busy, tx_ready, rx_data
  );

  modport master (
    output insert, data_to_send, ss, miso,
    input  sclk, mosi, cs_n, busy, tx_ready, rx_data
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master serialiser: shifts one word MSB-first per insert rising edge, then pulses tx_ready.
// Optional receive path enabled by defining SPI_RX_EN.
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int DATA_W  = 20,
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_tx_if.slave  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic              insert_q;
  logic              sclk;
  logic              mosi;
  logic [3:0]        cs_n;
  logic              busy;
  logic              tx_ready;
  logic              div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // insert_q resets high so an insert held through reset is not seen as a rising edge.
  // tx_shift holds the bits still to be sent; mosi already carries the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      insert_q <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 4'hF;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      insert_q <= bus.insert;
      tx_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.insert && !insert_q) begin
            state    <= ST_SETUP;
            busy     <= 1'b1;
            cs_n     <= ~(4'b0001 << bus.ss);
            mosi     <= bus.data_to_send[DATA_W-1];
            tx_shift <= bus.data_to_send << 1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (sclk) begin
              // Falling edge: advance mosi, except after the last bit where it is held.
              sclk <= 1'b0;
              if (bit_cnt != BIT_LAST) begin
                mosi     <= tx_shift[DATA_W-1];
                tx_shift <= tx_shift << 1;
              end
            end else if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_end) begin
            div_cnt  <= '0;
            state    <= ST_DONE;
            cs_n     <= 4'hF;
            tx_ready <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          mosi  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sclk     = sclk;
  assign bus.mosi     = mosi;
  assign bus.cs_n     = cs_n;
  assign bus.busy     = busy;
  assign bus.tx_ready = tx_ready;

`ifdef SPI_RX_EN
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;

  // miso is taken in the first clk of each sclk-high phase; the word is published as DONE begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state == ST_SHIFT && sclk && div_cnt == '0)
        rx_shift <= {rx_shift[DATA_W-2:0], bus.miso};
      if (state == ST_HOLD && div_end)
        rx_data <= rx_shift;
    end
  end

  assign bus.rx_data = rx_data;
`else
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign bus.rx_data = '0;
`endif
endmodule

// File: tb/tb_spi_master_tx.sv
// Randomised bench for spi_master_tx against a transfer-level reference model.
// miso is looped back to mosi so the receive path (SPI_RX_EN) can be checked too.
`timescale 1ns/1ps
module tb_spi_master_tx;
  localparam int DATA_W   = 20;
  localparam int CLK_DIV  = 2;
  localparam int XFER_CYC = (2*DATA_W + 2)*CLK_DIV + 1;
  localparam int WINDOW   = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_rx = '0;

  spi_master_tx_if #(.DATA_W(DATA_W)) bus ();
  assign bus.miso = bus.mosi;

  spi_master_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expRx(input logic [DATA_W-1:0] d);
`ifdef SPI_RX_EN
    return 32'(d);
`else
    return (d == d) ? 32'd0 : 32'd0;
`endif
  endfunction

  // One transfer: insert rises now (called just after a negedge), is held for `hold` cycles,
  // and an extra one-cycle insert pulse with junk data is fired at cycle `glitch_at` (0 = none).
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [1:0] sel,
                               input int hold, input int glitch_at, input string tag);
    logic [3:0]        exp_cs;
    logic [DATA_W-1:0] captured;
    logic [31:0]       exp_rx;
    logic [31:0]       rx_at_ready;
    logic              prev_sclk;
    logic              prev_mosi;
    int rises, ready_cnt, ready_cyc, cs_bad, busy_bad, unstable, rx_bad;
    exp_cs      = ~(4'b0001 << sel);
    exp_rx      = expRx(data);
    captured    = '0;
    rx_at_ready = '0;
    prev_sclk   = 1'b0;
    prev_mosi   = 1'b0;
    rises = 0; ready_cnt = 0; ready_cyc = 0; cs_bad = 0; busy_bad = 0; unstable = 0; rx_bad = 0;
    bus.data_to_send = data;
    bus.ss           = sel;
    bus.insert       = 1'b1;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      if (bus.sclk && !prev_sclk) begin
        captured = {captured[DATA_W-2:0], bus.mosi};
        rises++;
        if (bus.mosi !== prev_mosi) unstable++;
      end
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
      if (bus.tx_ready) begin
        ready_cnt++;
        if (ready_cyc == 0) ready_cyc = cyc;
        rx_at_ready = 32'(bus.rx_data);
      end
      if (bus.cs_n !== ((cyc < XFER_CYC) ? exp_cs : 4'hF)) cs_bad++;
      if (bus.busy !== (cyc <= XFER_CYC)) busy_bad++;
      if (32'(bus.rx_data) !== ((cyc >= XFER_CYC) ? exp_rx : last_rx)) rx_bad++;
      bus.insert = (cyc < hold) || (cyc == glitch_at);
      if (cyc == glitch_at) begin
        bus.data_to_send = 20'h00001;
        bus.ss           = ~sel;
      end else begin
        bus.data_to_send = DATA_W'($urandom);
        bus.ss           = 2'($urandom);
      end
    end
    bus.insert = 1'b0;
    last_rx = exp_rx;
    checkOutput({tag, "_word"},      32'(captured), 32'(data));
    checkOutput({tag, "_rises"},     32'(rises),    32'(DATA_W));
    checkOutput({tag, "_ready_cyc"}, 32'(ready_cyc), 32'(XFER_CYC));
    checkOutput({tag, "_ready_cnt"}, 32'(ready_cnt), 32'd1);
    checkOutput({tag, "_cs_bad"},    32'(cs_bad),   32'd0);
    checkOutput({tag, "_busy_bad"},  32'(busy_bad), 32'd0);
    checkOutput({tag, "_unstable"},  32'(unstable), 32'd0);
    checkOutput({tag, "_rx_bad"},    32'(rx_bad),   32'd0);
    checkOutput({tag, "_rx_ready"},  rx_at_ready,   exp_rx);
  endtask

  initial begin
    int seen_busy, seen_cs, seen_ready;
    bus.insert       = 1'b1;
    bus.data_to_send = 20'hD5AC2;
    bus.ss           = 2'd0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk",  32'(bus.sclk),     32'd0);
    checkOutput("rst_mosi",  32'(bus.mosi),     32'd0);
    checkOutput("rst_cs",    32'(bus.cs_n),     32'hF);
    checkOutput("rst_busy",  32'(bus.busy),     32'd0);
    checkOutput("rst_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("rst_rx",    32'(bus.rx_data),  32'd0);

    // insert held high across reset release must not start anything
    rst = 1'b0;
    seen_busy = 0; seen_cs = 0; seen_ready = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) seen_busy++;
      if (bus.cs_n !== 4'hF) seen_cs++;
      if (bus.tx_ready) seen_ready++;
    end
    checkOutput("held_busy",  32'(seen_busy),  32'd0);
    checkOutput("held_cs",    32'(seen_cs),    32'd0);
    checkOutput("held_ready", 32'(seen_ready), 32'd0);
    bus.insert = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(20'hD5AC2, 2'd0, 1,   0,        "basic");
    applyStimulus(20'hD5AD2, 2'd3, 100, 0,        "held");
    applyStimulus(20'hD5AC2, 2'd0, 1,   30,       "midpulse");
    applyStimulus(20'h3C96E, 2'd2, 1,   XFER_CYC, "done_edge");

    // reset in the middle of a transfer
    bus.data_to_send = 20'hD5AC2;
    bus.ss           = 2'd2;
    bus.insert       = 1'b1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.insert = 1'b0;
    end
    @(negedge clk);
    checkOutput("midrst_busy_pre", 32'(bus.busy), 32'd1);
    checkOutput("midrst_cs_pre",   32'(bus.cs_n), 32'hB);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cs",    32'(bus.cs_n),     32'hF);
    checkOutput("midrst_sclk",  32'(bus.sclk),     32'd0);
    checkOutput("midrst_ready", 32'(bus.tx_ready), 32'd0);
    checkOutput("midrst_busy",  32'(bus.busy),     32'd0);
    checkOutput("midrst_rx",    32'(bus.rx_data),  32'd0);
    last_rx = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(20'hD5AC2, 2'd2, 1, 0, "after_rst");
    applyStimulus(20'hA5A5A, 2'd1, 1, 0, "loopback");

    for (int n = 0; n < 8; n++) begin
      applyStimulus(DATA_W'($urandom), 2'($urandom), int'($urandom_range(1, 4)),
                    (($urandom & 1) != 0) ? int'($urandom_range(2, XFER_CYC)) : 0, "rand");
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
